uart_rx_core: RTL

Parametrised UART receive core: oversamples an asynchronous serial line on a baud tick, reassembles LSB-first frames of configurable width and stop-bit count, checks framing (and optionally parity), and buffers received words in a small FIFO drained by a valid/ready handshake. It replaces the fixed 8-bit `RX` receiver, keeps its `RXD`/`RXC`/`RX_END`/`DQ` signal set, and sits between the pad synchroniser-free serial input and the bus-side register block.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/uart_rx_core.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state to the receiver FSM.
package uart_pkg;

    localparam int DATA_W_MIN     = 5;
    localparam int DATA_W_MAX     = 9;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int OVERSAMPLE_MAX = 32;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Parity bit the transmitter should have sent for a zero-extended data word.
    function automatic logic expectedParity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive word FIFO with a registered head word; a word pushed into an empty
// FIFO reaches the head one clock later, and capacity is exactly DEPTH words.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] pushData_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic [DATA_W-1:0] head_o,
    output logic              valid_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q, rdPtr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] head_q;
    logic              valid_q;
    logic              pop, pushOk, load;

    // count_q tracks words still in the array; the head register holds one more.
    assign pop    = pop_i && valid_q;
    assign full_o = (count_q + CW'(valid_q)) == CW'(DEPTH);
    assign pushOk = push_i && (!full_o || pop);
    assign load   = (!valid_q || pop) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({pushOk, load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (load) begin
                head_q  <= mem_q[rdPtr_q];
                rdPtr_q <= rdPtr_q + 1'b1;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises RXD, oversamples on RXC, checks framing and queues good words.
// Define UART_RX_PARITY_EN to build the optional parity bit check and PARITY_ERR.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RXD,
    input  logic              RXC,
    input  logic              parity_en,
    input  logic              parity_odd,
    output logic [DATA_W-1:0] DQ,
    output logic              DQ_VALID,
    input  logic              DQ_READY,
    output logic              RX_END,
    output logic              FRAME_ERR,
    output logic              PARITY_ERR,
    output logic              OVERRUN
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic [1:0]        syncFf_q;
    logic              rxdS;
    rx_state_t         state_q, state_d;
    logic [TW-1:0]     tickCnt_q, tickCnt_d;
    logic [BW-1:0]     bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
    logic              stopErr_q, stopErr_d;
    logic              rxEnd_q, rxEnd_d;
    logic              frameErr_q, frameErr_d;
    logic              overrun_q, overrun_d;
    logic              frameBad, frameGood, push, pop, fifoFull;
`ifdef UART_RX_PARITY_EN
    logic              parEn_q, parOdd_q;
    logic              parErr_q, parErr_d;
    logic              parErrPulse_q, parErrPulse_d;
`else
    logic              unusedParity;
    assign unusedParity = parity_en ^ parity_odd;
`endif

    assign rxdS = syncFf_q[1];
    assign pop  = DQ_VALID && DQ_READY;

    // Counters only move on RXC; a frame's verdict is decided on its last stop sample.
    always_comb begin
        state_d    = state_q;
        tickCnt_d  = tickCnt_q;
        bitCnt_d   = bitCnt_q;
        shiftReg_d = shiftReg_q;
        stopErr_d  = stopErr_q;
        rxEnd_d    = 1'b0;
        frameErr_d = 1'b0;
        overrun_d  = 1'b0;
        frameBad   = 1'b0;
        frameGood  = 1'b0;
        push       = 1'b0;
`ifdef UART_RX_PARITY_EN
        parErr_d      = parErr_q;
        parErrPulse_d = 1'b0;
`endif
        if (RXC) begin
            case (state_q)
                IDLE: begin
                    if (!rxdS) begin
                        state_d   = START;
                        tickCnt_d = '0;
                        bitCnt_d  = '0;
                        stopErr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        parErr_d  = 1'b0;
`endif
                    end
                end
                START: begin
                    if (tickCnt_q == TICK_MID) begin
                        tickCnt_d = '0;
                        state_d   = rxdS ? IDLE : DATA;
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tickCnt_q == TICK_LAST) begin
                        tickCnt_d  = '0;
                        shiftReg_d = {rxdS, shiftReg_q[DATA_W-1:1]};
                        if (bitCnt_q == BIT_LAST) begin
                            bitCnt_d = '0;
                            state_d  = STOP;
`ifdef UART_RX_PARITY_EN
                            if (parEn_q) begin
                                state_d = PARITY;
                            end
`endif
                        end else begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tickCnt_q == TICK_LAST) begin
                        tickCnt_d = '0;
                        parErr_d  = rxdS != expectedParity(16'(shiftReg_q), parOdd_q);
                        state_d   = STOP;
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tickCnt_q == TICK_LAST) begin
                        tickCnt_d = '0;
                        if (bitCnt_q == STOP_LAST) begin
                            bitCnt_d   = '0;
                            frameBad   = stopErr_q || !rxdS;
`ifdef UART_RX_PARITY_EN
                            frameGood     = !frameBad && !parErr_q;
                            parErrPulse_d = !frameBad && parErr_q;
`else
                            frameGood     = !frameBad;
`endif
                            rxEnd_d    = 1'b1;
                            frameErr_d = frameBad;
                            push       = frameGood && (!fifoFull || pop);
                            overrun_d  = frameGood && fifoFull && !pop;
                            state_d    = rxdS ? IDLE : WAIT_IDLE;
                        end else begin
                            bitCnt_d  = bitCnt_q + 1'b1;
                            stopErr_d = stopErr_q || !rxdS;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rxdS) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncFf_q   <= 2'b11;
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            stopErr_q  <= 1'b0;
            rxEnd_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            syncFf_q   <= {syncFf_q[0], RXD};
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            bitCnt_q   <= bitCnt_d;
            shiftReg_q <= shiftReg_d;
            stopErr_q  <= stopErr_d;
            rxEnd_q    <= rxEnd_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity configuration is frozen for the whole frame once we leave IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parEn_q       <= 1'b0;
            parOdd_q      <= 1'b0;
            parErr_q      <= 1'b0;
            parErrPulse_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                parEn_q  <= parity_en;
                parOdd_q <= parity_odd;
            end
            parErr_q      <= parErr_d;
            parErrPulse_q <= parErrPulse_d;
        end
    end

    assign PARITY_ERR = parErrPulse_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

    assign RX_END    = rxEnd_q;
    assign FRAME_ERR = frameErr_q;
    assign OVERRUN   = overrun_q;

    uart_rx_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pushData_i(shiftReg_q),
        .pop_i     (DQ_READY),
        .full_o    (fifoFull),
        .head_o    (DQ),
        .valid_o   (DQ_VALID)
    );

endmodule
